// File: rtl/decode_pkg.sv
// Shared definitions for the RV32I main-decode stage: opcodes, ALU-op
// encodings, immediate formats and the packed control bundle.
package decode_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    typedef enum logic [2:0] {
        FMT_NONE,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } imm_fmt_e;

    typedef struct packed {
        logic       regwrite;
        logic       alusrc;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       branch;
        logic       jump;
        logic [1:0] aluop;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate generator: selects the RV32I immediate layout
// for the given format and sign-extends it from instr[31] to XLEN.
module imm_gen
    import decode_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr_i,
    input  imm_fmt_e        fmt_i,
    output logic [XLEN-1:0] imm_o
);

    logic [31:0] imm32;

    // Assemble the 32-bit immediate for the selected format.
    always_comb begin
        imm32 = '0;
        unique case (fmt_i)
            FMT_I:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            FMT_S:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            FMT_B:   imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                              instr_i[30:25], instr_i[11:8], 1'b0};
            FMT_U:   imm32 = {instr_i[31:12], 12'h000};
            FMT_J:   imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                              instr_i[20], instr_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Signed cast replicates bit 31 out to the full datapath width.
    assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I main-decode stage with valid/ready handshake, flush,
// illegal-opcode flagging and a saturating illegal-instruction counter.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ILL_CNT_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          instr_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic                 flush_i,
    input  logic                 ready_i,
    output logic                 valid_o,
    output logic                 regwrite_o,
    output logic                 alusrc_o,
    output logic                 memread_o,
    output logic                 memwrite_o,
    output logic                 memtoreg_o,
    output logic                 branch_o,
    output logic                 jump_o,
    output logic [1:0]           aluop_o,
    output logic [4:0]           rd_o,
    output logic [4:0]           rs1_o,
    output logic [4:0]           rs2_o,
    output logic [XLEN-1:0]      imm_o,
    output logic                 illegal_o,
    output logic [ILL_CNT_W-1:0] ill_cnt_o
);

    ctrl_t                ctrl_d, ctrl_q;
    imm_fmt_e             fmt_d;
    logic [XLEN-1:0]      imm_d, imm_q;
    logic [4:0]           rd_q, rs1_q, rs2_q;
    logic                 valid_q;
    logic [ILL_CNT_W-1:0] ill_cnt_q;
    logic                 accept;

    assign ready_o = !valid_q | ready_i;
    // Flush drops the incoming instruction, so it never counts as accepted.
    assign accept  = valid_i & ready_o & !flush_i;

    // Main opcode decode into the control bundle and immediate format.
    always_comb begin
        ctrl_d = '0;
        fmt_d  = FMT_NONE;
        unique case (instr_i[6:0])
            OP_R: begin
                ctrl_d.regwrite = 1'b1;
                ctrl_d.aluop    = ALUOP_R;
            end
            OP_I: begin
                ctrl_d.regwrite = 1'b1;
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.aluop    = ALUOP_I;
                fmt_d           = FMT_I;
            end
            OP_LOAD: begin
                ctrl_d.regwrite = 1'b1;
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.memread  = 1'b1;
                ctrl_d.memtoreg = 1'b1;
                fmt_d           = FMT_I;
            end
            OP_STORE: begin
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.memwrite = 1'b1;
                fmt_d           = FMT_S;
            end
            OP_BRANCH: begin
                ctrl_d.branch   = 1'b1;
                ctrl_d.aluop    = ALUOP_BR;
                fmt_d           = FMT_B;
            end
            OP_JAL: begin
                ctrl_d.regwrite = 1'b1;
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.jump     = 1'b1;
                fmt_d           = FMT_J;
            end
            OP_JALR: begin
                ctrl_d.regwrite = 1'b1;
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.jump     = 1'b1;
                fmt_d           = FMT_I;
            end
            OP_LUI, OP_AUIPC: begin
                ctrl_d.regwrite = 1'b1;
                ctrl_d.alusrc   = 1'b1;
                fmt_d           = FMT_U;
            end
            default: ctrl_d.illegal = 1'b1;
        endcase
        // Writes to x0 are architecturally discarded.
        if (instr_i[11:7] == 5'd0) begin
            ctrl_d.regwrite = 1'b0;
        end
    end

    imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .instr_i (instr_i),
        .fmt_i   (fmt_d),
        .imm_o   (imm_d)
    );

    // Output register, handshake state and saturating illegal counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            imm_q     <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            ill_cnt_q <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            ctrl_q  <= ctrl_d;
            imm_q   <= imm_d;
            rd_q    <= instr_i[11:7];
            rs1_q   <= instr_i[19:15];
            rs2_q   <= instr_i[24:20];
            if (ctrl_d.illegal && (ill_cnt_q != '1)) begin
                ill_cnt_q <= ill_cnt_q + ILL_CNT_W'(1);
            end
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o    = valid_q;
    assign regwrite_o = ctrl_q.regwrite;
    assign alusrc_o   = ctrl_q.alusrc;
    assign memread_o  = ctrl_q.memread;
    assign memwrite_o = ctrl_q.memwrite;
    assign memtoreg_o = ctrl_q.memtoreg;
    assign branch_o   = ctrl_q.branch;
    assign jump_o     = ctrl_q.jump;
    assign aluop_o    = ctrl_q.aluop;
    assign illegal_o  = ctrl_q.illegal;
    assign rd_o       = rd_q;
    assign rs1_o      = rs1_q;
    assign rs2_o      = rs2_q;
    assign imm_o      = imm_q;
    assign ill_cnt_o  = ill_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_i, valid_i, flush_i, ready_i;
    logic [31:0] instr_i;
    logic        ready_o, valid_o, regwrite_o, alusrc_o, memread_o, memwrite_o;
    logic        memtoreg_o, branch_o, jump_o, illegal_o;
    logic [1:0]  aluop_o;
    logic [4:0]  rd_o, rs1_o, rs2_o;
    logic [31:0] imm_o;
    logic [7:0]  ill_cnt_o;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cnt_model;

    always #5 clk = ~clk;

    decode_stage #(
        .XLEN      (32),
        .ILL_CNT_W (8)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .instr_i    (instr_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .flush_i    (flush_i),
        .ready_i    (ready_i),
        .valid_o    (valid_o),
        .regwrite_o (regwrite_o),
        .alusrc_o   (alusrc_o),
        .memread_o  (memread_o),
        .memwrite_o (memwrite_o),
        .memtoreg_o (memtoreg_o),
        .branch_o   (branch_o),
        .jump_o     (jump_o),
        .aluop_o    (aluop_o),
        .rd_o       (rd_o),
        .rs1_o      (rs1_o),
        .rs2_o      (rs2_o),
        .imm_o      (imm_o),
        .illegal_o  (illegal_o),
        .ill_cnt_o  (ill_cnt_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Control bits packed as {rw,src,mrd,mwr,m2r,br,jmp,aluop[1:0],illegal}.
    function automatic logic [31:0] ctrl_vec();
        return {22'd0, regwrite_o, alusrc_o, memread_o, memwrite_o, memtoreg_o,
                branch_o, jump_o, aluop_o, illegal_o};
    endfunction

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1; instr_i = '0;
        tick(); tick();
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_ready", {31'd0, ready_o}, 32'd1);
        check("rst_cnt",   {24'd0, ill_cnt_o}, 32'd0);
        check("rst_imm",   imm_o, 32'd0);
        check("rst_ctrl",  ctrl_vec(), 32'd0);

        // ADD x3,x1,x2
        rst_i = 1'b0; valid_i = 1'b1; instr_i = 32'h002081B3;
        tick();
        check("add_valid", {31'd0, valid_o}, 32'd1);
        check("add_ctrl",  ctrl_vec(), 32'b1_0_0_0_0_0_0_10_0);
        check("add_regs",  {17'd0, rd_o, rs1_o, rs2_o}, {17'd0, 5'd3, 5'd1, 5'd2});
        check("add_imm",   imm_o, 32'd0);

        // ADDI x1,x0,-1 back to back
        instr_i = 32'hFFF00093;
        tick();
        check("addi_ctrl", ctrl_vec(), 32'b1_1_0_0_0_0_0_11_0);
        check("addi_imm",  imm_o, 32'hFFFFFFFF);
        check("addi_regs", {22'd0, rd_o, rs1_o}, {22'd0, 5'd1, 5'd0});

        // SW x2,8(x1) then stall 3 cycles while BEQ waits at the input
        instr_i = 32'h0020A423;
        tick();
        check("sw_ctrl", ctrl_vec(), 32'b0_1_0_1_0_0_0_00_0);
        check("sw_imm",  imm_o, 32'd8);
        ready_i = 1'b0; instr_i = 32'hFE000EE3;
        #1;
        check("stall_ready", {31'd0, ready_o}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", {31'd0, valid_o}, 32'd1);
            check("stall_ready", {31'd0, ready_o}, 32'd0);
            check("stall_ctrl",  ctrl_vec(), 32'b0_1_0_1_0_0_0_00_0);
            check("stall_imm",   imm_o, 32'd8);
            check("stall_regs",  {17'd0, rd_o, rs1_o, rs2_o}, {17'd0, 5'd8, 5'd1, 5'd2});
        end
        ready_i = 1'b1;
        #1;
        check("unstall_ready", {31'd0, ready_o}, 32'd1);
        tick();
        check("beq_ctrl", ctrl_vec(), 32'b0_0_0_0_0_1_0_01_0);
        check("beq_imm",  imm_o, 32'hFFFFFFFC);

        // Idle cycle drains the stage
        valid_i = 1'b0;
        tick();
        check("idle_valid", {31'd0, valid_o}, 32'd0);

        // ADDI x0,x0,1: write to x0 suppressed
        valid_i = 1'b1; instr_i = 32'h00100013;
        tick();
        check("x0_ctrl", ctrl_vec(), 32'b0_1_0_0_0_0_0_11_0);
        check("x0_imm",  imm_o, 32'd1);

        // JAL x1,8
        instr_i = 32'h008000EF;
        tick();
        check("jal_ctrl", ctrl_vec(), 32'b1_1_0_0_0_0_1_00_0);
        check("jal_imm",  imm_o, 32'd8);

        // LUI x5,0x12345
        instr_i = 32'h123452B7;
        tick();
        check("lui_ctrl", ctrl_vec(), 32'b1_1_0_0_0_0_0_00_0);
        check("lui_imm",  imm_o, 32'h12345000);
        check("lui_rd",   {27'd0, rd_o}, 32'd5);

        // LW x4,-8(x2)
        instr_i = 32'hFF812203;
        tick();
        check("lw_ctrl", ctrl_vec(), 32'b1_1_1_0_1_0_0_00_0);
        check("lw_imm",  imm_o, 32'hFFFFFFF8);

        // One illegal opcode
        instr_i = 32'h0000007F;
        tick();
        check("ill_ctrl",  ctrl_vec(), 32'd1);
        check("ill_valid", {31'd0, valid_o}, 32'd1);
        check("ill_imm",   imm_o, 32'd0);
        check("ill_cnt",   {24'd0, ill_cnt_o}, 32'd1);

        // Flush with an incoming illegal instruction: dropped, not counted
        flush_i = 1'b1;
        tick();
        check("flush_valid", {31'd0, valid_o}, 32'd0);
        check("flush_cnt",   {24'd0, ill_cnt_o}, 32'd1);
        flush_i = 1'b0;

        // 300 illegal instructions back to back; counter saturates at 255
        cnt_model = 1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (cnt_model < 255) cnt_model++;
            check("sat_illegal", {31'd0, illegal_o}, 32'd1);
            check("sat_cnt",     {24'd0, ill_cnt_o}, cnt_model);
        end
        check("sat_final", {24'd0, ill_cnt_o}, 32'd255);

        // Reset during a stall loses the held instruction
        instr_i = 32'h002081B3;
        tick();
        ready_i = 1'b0; valid_i = 1'b0;
        tick();
        check("pre_rst_valid", {31'd0, valid_o}, 32'd1);
        rst_i = 1'b1;
        tick();
        check("midrst_valid", {31'd0, valid_o}, 32'd0);
        check("midrst_cnt",   {24'd0, ill_cnt_o}, 32'd0);
        check("midrst_rd",    {27'd0, rd_o}, 32'd0);
        check("midrst_ready", {31'd0, ready_o}, 32'd1);
        rst_i = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
